serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor computing A - B - bin over WIDTH bits. It processes CHUNK bits per clock through a registered borrow chain. This is the sequential, width-generic successor of the 1-bit full subtractor cell. It sits in datapath blocks where area matters more than latency, and uses a start/busy/done handshake.

Parameters:
WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits subtracted per clock cycle; 1 <= CHUNK <= WIDTH.
(derived) NCH = WIDTH/CHUNK, the number of processing cycles.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  minuend; captured when start is accepted.
b  input  WIDTH  subtrahend; captured when start is accepted.
bin  input  1  borrow-in; captured when start is accepted.
busy  output  1  high while an operation is in progress (RUN state).
done  output  1  one-cycle pulse when the result is valid.
diff  output  WIDTH  result A - B - bin mod 2^WIDTH; held until the next completion.
bout  output  1  final borrow-out, i.e. 1 when A < B + bin unsigned.

Behaviour:
- Reset: one clock, asynchronous, active-low. While rst_n=0:
  - state=IDLE, busy=0, done=0, diff=0, bout=0.
  - Operand regs, borrow reg and chunk counter are cleared.
  - Reset asserted mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at a rising edge: latch a, b, bin. Set borrow reg = bin, counter = 0. Go to RUN.
  - With start=0: stay in IDLE.
- RUN: busy=1. Each edge:
  - {borrow_next, d_chunk} = a_chunk[i] - b_chunk[i] - borrow, at CHUNK+1 bits unsigned. borrow_next is 1 when the result is negative.
  - Chunk i is taken LSB-first: bits [i*CHUNK +: CHUNK].
  - d_chunk is written into an internal result shift register; borrow reg = borrow_next; counter++.
  - On the edge that processes chunk NCH-1: load diff from the shift register plus the final chunk, load bout = borrow_next, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: if start is accepted at edge E, done is high in the cycle following edge E+NCH. diff/bout update at edge E+NCH.
- diff/bout keep the previous result throughout RUN. They change only at completion.
- start while in RUN or DONE is ignored. Operands are not re-sampled, and there is no queueing.
- start held continuously: a new operation is accepted on the first edge in IDLE after DONE. The throughput limit is one result per NCH+2 cycles.
- a/b/bin may change freely after acceptance without affecting the result.
- Counter width is clog2(NCH), minimum 1 bit.
- NCH=1 (CHUNK=WIDTH): RUN lasts one edge. The result equals a single-cycle registered subtractor.
- Borrow ripples correctly across chunk boundaries, e.g. 0x0000 - 1 propagates through all NCH chunks.

Optional Feature:
SERIAL_SUB_SIGNED_OVF_EN
- Defined:
  - Adds output port ovf (1 bit), reset 0.
  - ovf = borrow into the MSB XOR borrow out of the MSB, i.e. two's-complement overflow of A - B - bin.
  - Computed in the last RUN cycle and loaded together with diff/bout; held until the next completion.
- Undefined:
  - Port ovf and its logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=16, CHUNK=4: start with a=0x1234, b=0x0234, bin=0. Expect diff=0x1000, bout=0, busy high for 4 cycles, done pulse 4 edges after acceptance, done pulse exactly 1 cycle wide.
2. Full borrow ripple: a=0x0000, b=0x0001, bin=0. Expect diff=0xFFFF, bout=1. With the macro defined, ovf=0.
3. Signed overflow plus bin: a=0x8000, b=0x7FFF, bin=1. Expect diff=0x0000, bout=0. With the macro defined, ovf=1.
4. Ignored start: accept a=0x00FF, b=0x000F. Pulse start with a=0xFFFF, b=0xFFFF during RUN. Expect diff=0x00F0 and only one done pulse; the previous diff stays stable during RUN.
5. Reset mid-operation: drop rst_n during the 2nd RUN cycle. Expect outputs to go to 0 immediately (asynchronously) and no done pulse. After release, a=5, b=3 gives diff=2, bout=0.
6. WIDTH=1, CHUNK=1 instance: all 8 {a,b,bin} combinations, checked against the full-subtractor truth table:
   - 000→d0 b0, 001→d1 b1, 010→d1 b1, 011→d0 b1
   - 100→d1 b0, 101→d0 b0, 110→d0 b0, 111→d1 b1

Source files
------------

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// serial_subtractor : multi-cycle A - B - bin, CHUNK bits per clock, LSB first.
// Optional macro SERIAL_SUB_SIGNED_OVF_EN adds the two's-complement ovf output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [CHUNK:0]   sub_res;
    logic [WIDTH-1:0] sr_shift;

    // Operands shift right each RUN cycle, so the active chunk is always the low CHUNK bits.
    assign sub_res  = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]}
                    - {{CHUNK{1'b0}}, borrow_q};
    assign sr_shift = WIDTH'({sub_res[CHUNK-1:0], sr_q} >> CHUNK);

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic ovf_q, ovf_d;
    logic ovf_next;

    // Borrow into the MSB equals a^b^d at that bit; XOR with borrow-out gives overflow.
    assign ovf_next = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ sub_res[CHUNK-1] ^ sub_res[CHUNK];
    assign ovf      = ovf_q;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sr_d     = sr_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        done     = 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                a_d      = a_q >> CHUNK;
                b_d      = b_q >> CHUNK;
                sr_d     = sr_shift;
                borrow_d = sub_res[CHUNK];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == C_LAST) begin
                    diff_d  = sr_shift;
                    bout_d  = sub_res[CHUNK];
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    ovf_d   = ovf_next;
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sr_q     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sr_q     <= sr_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

`default_nettype wire
